// File: rtl/sx_wrr_arbiter_if.sv
// Request/grant bundle between one output port's stream mux and its WRR arbiter.
// The arbiter takes the slave side; the crossbar datapath (or a bench) drives the master side.
interface sx_wrr_arbiter_if #(
  parameter int S_DATA_COUNT = 10,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int ID_WIDTH = $clog2(S_DATA_COUNT);

  logic [S_DATA_COUNT-1:0]              req_i;
  logic [S_DATA_COUNT-1:0]              last_i;
  logic                                 beat_ack_i;
  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i;
  logic [S_DATA_COUNT-1:0]              grant_o;
  logic [ID_WIDTH-1:0]                  grant_id_o;
  logic                                 grant_valid_o;
  logic                                 pkt_done_o;

  modport master (
    output req_i, last_i, beat_ack_i, weight_i,
    input  grant_o, grant_id_o, grant_valid_o, pkt_done_o
  );

  modport slave (
    input  req_i, last_i, beat_ack_i, weight_i,
    output grant_o, grant_id_o, grant_valid_o, pkt_done_o
  );
endinterface

// File: rtl/sx_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter for one crossbar output port.
// Grants are held until the owner's last beat handshakes; each owner may keep up to WEIGHT packets per turn.
module sx_wrr_arbiter #(
  parameter int S_DATA_COUNT = 10,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  sx_wrr_arbiter_if.slave arb
);
  localparam int ID_WIDTH = $clog2(S_DATA_COUNT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0]   credit_q, credit_d;
  logic [ID_WIDTH-1:0]       owner_q, owner_d;
  logic [S_DATA_COUNT-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]       grantId_q, grantId_d;
  logic                      grantValid_q, grantValid_d;
  logic                      pktDone_q, pktDone_d;

  logic                      scanFound;
  logic [ID_WIDTH-1:0]       scanSel;
  logic [WEIGHT_WIDTH-1:0]   selWeight;
  logic [ID_WIDTH-1:0]       sel;
  logic                      take;
  logic                      reload;

  // Rotating priority: first requester at or after ptr_q, wrapping modulo S_DATA_COUNT.
  always_comb begin
    scanFound = 1'b0;
    scanSel   = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= S_DATA_COUNT) idx = idx - S_DATA_COUNT;
      if (!scanFound && arb.req_i[idx]) begin
        scanFound = 1'b1;
        scanSel   = ID_WIDTH'(idx);
      end
    end
  end

  assign selWeight = arb.weight_i[int'(scanSel)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    credit_d     = credit_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    grantId_d    = grantId_q;
    grantValid_d = grantValid_q;
    pktDone_d    = 1'b0;
    sel          = '0;
    take         = 1'b0;
    reload       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Remaining credit lets the previous owner keep its turn without reloading weight.
        if (credit_q != '0 && arb.req_i[owner_q]) begin
          take = 1'b1;
          sel  = owner_q;
        end else if (scanFound) begin
          take   = 1'b1;
          reload = 1'b1;
          sel    = scanSel;
        end
        if (take) begin
          state_d      = LOCKED;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          grantId_d    = sel;
          grantValid_d = 1'b1;
        end
        if (reload) begin
          credit_d = (selWeight == '0) ? WEIGHT_WIDTH'(1) : selWeight;
          ptr_d    = (sel == ID_WIDTH'(S_DATA_COUNT - 1)) ? '0 : sel + 1'b1;
          owner_d  = sel;
        end
      end
      LOCKED: begin
        if (arb.beat_ack_i && arb.last_i[grantId_q]) begin
          state_d      = IDLE;
          credit_d     = (credit_q == '0) ? '0 : credit_q - 1'b1;
          grant_d      = '0;
          grantValid_d = 1'b0;
          pktDone_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      credit_q     <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      grantId_q    <= '0;
      grantValid_q <= 1'b0;
      pktDone_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      grantId_q    <= grantId_d;
      grantValid_q <= grantValid_d;
      pktDone_q    <= pktDone_d;
    end
  end

  assign arb.grant_o       = grant_q;
  assign arb.grant_id_o    = grantId_q;
  assign arb.grant_valid_o = grantValid_q;
  assign arb.pkt_done_o    = pktDone_q;
endmodule

// File: tb/tb_sx_wrr_arbiter.sv
// Scoreboard bench for sx_wrr_arbiter at S_DATA_COUNT=4: expected grant owners are queued
// with the stimulus and popped whenever a new grant appears.
module tb_sx_wrr_arbiter;
  localparam int S   = 4;
  localparam int W   = 4;
  localparam int IDW = $clog2(S);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   expQ[$];

  always #5 clk = ~clk;

  sx_wrr_arbiter_if #(.S_DATA_COUNT(S), .WEIGHT_WIDTH(W)) bus ();

  sx_wrr_arbiter #(.S_DATA_COUNT(S), .WEIGHT_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (bus.slave)
  );

  task automatic applyStimulus(input logic [S-1:0] req, input logic [S-1:0] last,
                               input logic ack, input logic [S*W-1:0] weight);
    bus.req_i      = req;
    bus.last_i     = last;
    bus.beat_ack_i = ack;
    bus.weight_i   = weight;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 16'h1111);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 16'h1111);
    #13;
    checks++;
    if (bus.grant_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_grant: got %b, expected 0000", bus.grant_o);
    end
    checks++;
    if ({bus.grant_id_o, bus.grant_valid_o, bus.pkt_done_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got id=%0d valid=%b done=%b, expected all 0",
               bus.grant_id_o, bus.grant_valid_o, bus.pkt_done_o);
    end
  endtask

  task automatic test_single_packet();
    int exp;
    logic [S-1:0] expGrant;
    resetDut();
    applyStimulus(4'b0001, 4'b0000, 1'b0, 16'h1111);
    expQ.push_back(0);
    @(negedge clk);
    exp = expQ.pop_front();
    expGrant = '0;
    expGrant[exp] = 1'b1;
    checks++;
    if (bus.grant_o !== expGrant || bus.grant_valid_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pkt_first_grant: got %b valid=%b, expected %b valid=1",
               bus.grant_o, bus.grant_valid_o, expGrant);
    end
    for (int b = 0; b < 3; b++) begin
      applyStimulus(4'b0001, (b == 2) ? 4'b0001 : 4'b0000, 1'b1, 16'h1111);
      @(negedge clk);
      if (b < 2) begin
        checks++;
        if (bus.grant_o !== expGrant || bus.pkt_done_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL pkt_mid_beat%0d: got grant=%b done=%b, expected grant=%b done=0",
                   b, bus.grant_o, bus.pkt_done_o, expGrant);
        end
      end else begin
        checks++;
        if (bus.grant_o !== '0 || bus.pkt_done_o !== 1'b1 || bus.grant_valid_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL pkt_end: got grant=%b done=%b valid=%b, expected grant=0000 done=1 valid=0",
                   bus.grant_o, bus.pkt_done_o, bus.grant_valid_o);
        end
      end
    end
    applyStimulus('0, '0, 1'b0, 16'h1111);
    @(negedge clk);
    checks++;
    if (bus.pkt_done_o !== 1'b0 || bus.grant_o !== '0) begin
      failures++;
      $display("[TB] FAIL pkt_done_single_pulse: got done=%b grant=%b, expected done=0 grant=0000",
               bus.pkt_done_o, bus.grant_o);
    end
  endtask

  // Single-beat packets, acked whenever granted; expQ holds the expected owner order.
  task automatic test_single_beat_stream(input string name, input logic [S-1:0] reqv,
                                         input logic [S*W-1:0] w);
    bit prevValid = 1'b0;
    int lastStart = -1;
    int exp;
    logic [S-1:0] expGrant;
    resetDut();
    applyStimulus(reqv, '1, 1'b0, w);
    for (int cyc = 0; cyc < 200 && expQ.size() > 0; cyc++) begin
      @(negedge clk);
      if (bus.grant_valid_o && !prevValid) begin
        exp = expQ.pop_front();
        expGrant = '0;
        expGrant[exp] = 1'b1;
        checks++;
        if (bus.grant_o !== expGrant || bus.grant_id_o !== IDW'(exp)) begin
          failures++;
          $display("[TB] FAIL %s_grant: got grant=%b id=%0d, expected grant=%b id=%0d",
                   name, bus.grant_o, bus.grant_id_o, expGrant, exp);
        end
        if (lastStart >= 0) begin
          checks++;
          if (cyc - lastStart !== 2) begin
            failures++;
            $display("[TB] FAIL %s_gap: got %0d cycles between grants, expected 2",
                     name, cyc - lastStart);
          end
        end
        lastStart = cyc;
      end
      prevValid = bus.grant_valid_o;
      bus.beat_ack_i = bus.grant_valid_o;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got %0d grants outstanding, expected 0", name, expQ.size());
      expQ.delete();
    end
    @(negedge clk);
    checks++;
    if (bus.pkt_done_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_final_done: got %b, expected 1", name, bus.pkt_done_o);
    end
    applyStimulus('0, '0, 1'b0, w);
    @(negedge clk);
  endtask

  task automatic test_hold();
    int exp;
    logic [S-1:0] expGrant;
    resetDut();
    applyStimulus(4'b0100, 4'b0000, 1'b0, 16'h1111);
    expQ.push_back(2);
    @(negedge clk);
    exp = expQ.pop_front();
    expGrant = '0;
    expGrant[exp] = 1'b1;
    checks++;
    if (bus.grant_o !== expGrant || bus.grant_id_o !== IDW'(exp)) begin
      failures++;
      $display("[TB] FAIL hold_initial: got grant=%b id=%0d, expected grant=%b id=%0d",
               bus.grant_o, bus.grant_id_o, expGrant, exp);
    end
    // Owner drops its request halfway; acks without last and lasts without ack must not release.
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i < 10) ? 4'b0101 : 4'b0001, i[0] ? 4'b0000 : 4'b0100, i[0], 16'h1111);
      @(negedge clk);
      checks++;
      if (bus.grant_o !== expGrant || bus.pkt_done_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d: got grant=%b done=%b, expected grant=%b done=0",
                 i, bus.grant_o, bus.pkt_done_o, expGrant);
      end
    end
    applyStimulus(4'b0001, 4'b0100, 1'b1, 16'h1111);
    @(negedge clk);
    checks++;
    if (bus.grant_o !== '0 || bus.pkt_done_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_release: got grant=%b done=%b, expected grant=0000 done=1",
               bus.grant_o, bus.pkt_done_o);
    end
    applyStimulus(4'b0001, 4'b0000, 1'b1, 16'h1111);
    expQ.push_back(0);
    @(negedge clk);
    exp = expQ.pop_front();
    expGrant = '0;
    expGrant[exp] = 1'b1;
    checks++;
    if (bus.grant_o !== expGrant) begin
      failures++;
      $display("[TB] FAIL hold_next_owner: got %b, expected %b", bus.grant_o, expGrant);
    end
    applyStimulus(4'b0000, 4'b0001, 1'b1, 16'h1111);
    @(negedge clk);
    applyStimulus('0, '0, 1'b0, 16'h1111);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    int exp;
    logic [S-1:0] expGrant;
    resetDut();
    applyStimulus(4'b1000, 4'b0000, 1'b0, 16'h1111);
    @(negedge clk);
    checks++;
    if (bus.grant_o !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL rstmid_grant3: got %b, expected 1000", bus.grant_o);
    end
    applyStimulus(4'b1000, 4'b0000, 1'b1, 16'h1111);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.grant_o !== '0 || bus.grant_valid_o !== 1'b0 || bus.grant_id_o !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_async_clear: got grant=%b valid=%b id=%0d, expected all 0",
               bus.grant_o, bus.grant_valid_o, bus.grant_id_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(4'b1001, 4'b0000, 1'b0, 16'h1111);
    expQ.push_back(0);
    @(negedge clk);
    exp = expQ.pop_front();
    expGrant = '0;
    expGrant[exp] = 1'b1;
    checks++;
    if (bus.grant_o !== expGrant) begin
      failures++;
      $display("[TB] FAIL rstmid_ptr_restart: got %b, expected %b", bus.grant_o, expGrant);
    end
    applyStimulus(4'b0000, 4'b0001, 1'b1, 16'h1111);
    @(negedge clk);
    applyStimulus('0, '0, 1'b0, 16'h1111);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_packet();
    expQ = '{0, 1, 2, 3, 0};
    test_single_beat_stream("rr_equal", 4'b1111, 16'h1111);
    expQ = '{0, 1, 1, 1, 2, 3, 0};
    test_single_beat_stream("wrr_weighted", 4'b1111, 16'h1131);
    test_hold();
    expQ = '{0, 0, 0, 0};
    test_single_beat_stream("zero_weight", 4'b0001, 16'h1110);
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
